// File: rtl/scrypt_pkg.sv
// Shared types and constants for the scrypt scratchpad controller: FSM state encoding,
// block/half-block widths and helpers to split a 1024-bit block into its X0/X1 halves.
package scrypt_pkg;

  localparam int unsigned SALSA_W               = 512;
  localparam int unsigned BLOCK_W               = 1024;
  localparam int unsigned SALSA_LATENCY_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWIssue,
    StWWait,
    StRFetch,
    StRData,
    StRIssue,
    StRWait,
    StDone
  } state_e;

  function automatic logic [SALSA_W-1:0] x0_of(input logic [BLOCK_W-1:0] blk);
    return blk[SALSA_W-1:0];
  endfunction

  function automatic logic [SALSA_W-1:0] x1_of(input logic [BLOCK_W-1:0] blk);
    return blk[BLOCK_W-1:SALSA_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] join_x(input logic [SALSA_W-1:0] x1,
                                                input logic [SALSA_W-1:0] x0);
    return {x1, x0};
  endfunction

endpackage

// File: rtl/scrypt_scratchpad_ctrl_if.sv
// Salsa-block and scratchpad-RAM signals of the scrypt scratchpad controller.
// master = controller side, slave = salsa core plus RAM side.
interface scrypt_scratchpad_ctrl_if #(
  parameter int unsigned N_LOG2 = 10
);

  logic [scrypt_pkg::SALSA_W-1:0] salsa_b;
  logic [scrypt_pkg::SALSA_W-1:0] salsa_bx;
  logic [scrypt_pkg::SALSA_W-1:0] salsa_bo;
  logic [scrypt_pkg::SALSA_W-1:0] salsa_x0out;
  logic [N_LOG2-1:0]              salsa_xaddr;

  logic [N_LOG2-1:0]              ram_addr;
  logic                           ram_we;
  logic [scrypt_pkg::BLOCK_W-1:0] ram_wdata;
  logic [scrypt_pkg::BLOCK_W-1:0] ram_rdata;

  modport master (
    output salsa_b, salsa_bx, ram_addr, ram_we, ram_wdata,
    input  salsa_bo, salsa_x0out, salsa_xaddr, ram_rdata
  );

  modport slave (
    input  salsa_b, salsa_bx, ram_addr, ram_we, ram_wdata,
    output salsa_bo, salsa_x0out, salsa_xaddr, ram_rdata
  );

endinterface

// File: rtl/scrypt_scratchpad_ctrl.sv
// scrypt ROMix scratchpad controller: writes V[0..N-1] through the salsa pipeline, then
// performs N data-dependent read/mix iterations. Optional cycle counter: SCRYPT_CTRL_CYCLE_COUNT_EN.
module scrypt_scratchpad_ctrl
  import scrypt_pkg::*;
#(
  parameter int unsigned N_LOG2        = 10,
  parameter int unsigned SALSA_LATENCY = SALSA_LATENCY_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BLOCK_W-1:0]       din,
  output logic                     busy,
  output logic                     done,
  output logic [BLOCK_W-1:0]       dout,
  output logic [31:0]              cycles,
  scrypt_scratchpad_ctrl_if.master bus
);

  localparam int unsigned IdxW = N_LOG2 + 1;
  localparam int unsigned CntW = $clog2(SALSA_LATENCY + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(2 ** N_LOG2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SALSA_LATENCY - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [SALSA_W-1:0]   x0_q, x0_d;
  logic [SALSA_W-1:0]   x1_q, x1_d;
  logic [SALSA_W-1:0]   b_q, b_d;
  logic [SALSA_W-1:0]   bx_q, bx_d;
  logic [N_LOG2-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic [BLOCK_W-1:0]   dout_q, dout_d;
  logic                 wait_last;
  logic                 idx_last;

  assign wait_last = (cnt_q == CntLast);
  assign idx_last  = (idx_q == IdxLast);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    b_d     = b_q;
    bx_d    = bx_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x0_d    = x0_of(din);
          x1_d    = x1_of(din);
          b_d     = x0_of(din);
          bx_d    = x1_of(din);
          idx_d   = '0;
          addr_d  = '0;
          we_d    = 1'b1;
          state_d = StWIssue;
        end
      end
      StWIssue: begin
        cnt_d   = '0;
        state_d = StWWait;
      end
      StWWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (wait_last) begin
          x0_d = bus.salsa_x0out;
          x1_d = bus.salsa_bo;
          if (idx_last) begin
            // The address register doubles as the Xaddr latch for the next fetch.
            idx_d   = '0;
            addr_d  = bus.salsa_xaddr;
            state_d = StRFetch;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            addr_d  = idx_d[N_LOG2-1:0];
            we_d    = 1'b1;
            b_d     = bus.salsa_x0out;
            bx_d    = bus.salsa_bo;
            state_d = StWIssue;
          end
        end
      end
      StRFetch: begin
        state_d = StRData;
      end
      StRData: begin
        b_d     = x0_q ^ x0_of(bus.ram_rdata);
        bx_d    = x1_q ^ x1_of(bus.ram_rdata);
        state_d = StRIssue;
      end
      StRIssue: begin
        cnt_d   = '0;
        state_d = StRWait;
      end
      StRWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (wait_last) begin
          x0_d = bus.salsa_x0out;
          x1_d = bus.salsa_bo;
          if (idx_last) begin
            dout_d  = join_x(bus.salsa_bo, bus.salsa_x0out);
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            addr_d  = bus.salsa_xaddr;
            state_d = StRFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      b_q     <= '0;
      bx_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      b_q     <= b_d;
      bx_q    <= bx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign dout          = dout_q;
  assign bus.salsa_b   = b_q;
  assign bus.salsa_bx  = bx_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_wdata = join_x(x1_q, x0_q);

`ifdef SCRYPT_CTRL_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Cleared on accept, counts busy cycles, saturates, then holds while idle.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == StIdle) begin
      if (start) begin
        cycles_d = '0;
      end
    end else if (cycles_q != '1) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_scrypt_scratchpad_ctrl.sv
// Bench for scrypt_scratchpad_ctrl with N_LOG2=2, a 16-cycle behavioural salsa stub
// (Bo=B+Bx+1, X0out=B^Bx, Xaddr=Bo[1:0] or forced 3) and a 1-cycle-read RAM model.
module tb_scrypt_scratchpad_ctrl;

  localparam int unsigned NLog2 = 2;
  localparam int unsigned Lat   = 16;
`ifdef SCRYPT_CTRL_CYCLE_COUNT_EN
  localparam int unsigned ExpCycles = 145;
`else
  localparam int unsigned ExpCycles = 0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [1023:0] din;
  logic          busy;
  logic          done;
  logic [1023:0] dout;
  logic [31:0]   cycles;
  bit            alias_mode;

  int n_checks;
  int n_err;

  scrypt_scratchpad_ctrl_if #(.N_LOG2(NLog2)) bus ();

  scrypt_scratchpad_ctrl #(
    .N_LOG2       (NLog2),
    .SALSA_LATENCY(Lat)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .cycles(cycles),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Salsa stub: result for inputs presented in cycle t is visible in cycle t+16.
  logic [511:0] stub_sum;
  logic [511:0] pb_bo [Lat];
  logic [511:0] pb_x0 [Lat];
  logic [1:0]   pb_xa [Lat];
  assign stub_sum = bus.salsa_b + bus.salsa_bx + 512'd1;

  always @(posedge clk) begin
    pb_bo[0] <= stub_sum;
    pb_x0[0] <= bus.salsa_b ^ bus.salsa_bx;
    pb_xa[0] <= alias_mode ? 2'd3 : stub_sum[1:0];
    for (int i = 1; i < Lat; i++) begin
      pb_bo[i] <= pb_bo[i-1];
      pb_x0[i] <= pb_x0[i-1];
      pb_xa[i] <= pb_xa[i-1];
    end
  end

  assign bus.salsa_bo    = pb_bo[Lat-1];
  assign bus.salsa_x0out = pb_x0[Lat-1];
  assign bus.salsa_xaddr = pb_xa[Lat-1];

  logic [1023:0] mem [4];
  logic [1023:0] rdata_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    rdata_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = rdata_q;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (low 96 bits)", nm, act[95:0], exp[95:0]);
    end
  endtask

  // Software ROMix with the stub salsa; returns dout, read indices and the written V blocks.
  task automatic model_run(input logic [1023:0] d, input bit al, output logic [1023:0] o,
                           output logic [7:0] ra, output logic [4095:0] vpk);
    logic [511:0]  x0, x1, b, bx;
    logic [1:0]    xa;
    logic [1023:0] v [4];
    x0 = d[511:0];
    x1 = d[1023:512];
    xa = '0;
    ra = '0;
    for (int i = 0; i < 4; i++) begin
      v[i] = {x1, x0};
      vpk[i*1024 +: 1024] = {x1, x0};
      b  = x0;
      bx = x1;
      x1 = b + bx + 512'd1;
      x0 = b ^ bx;
      xa = al ? 2'd3 : x1[1:0];
    end
    for (int i = 0; i < 4; i++) begin
      ra[i*2 +: 2] = xa;
      b  = x0 ^ v[xa][511:0];
      bx = x1 ^ v[xa][1023:512];
      x1 = b + bx + 512'd1;
      x0 = b ^ bx;
      xa = al ? 2'd3 : x1[1:0];
    end
    o = {x1, x0};
  endtask

  task automatic run_one(input string nm, input logic [1023:0] d, input bit al, input bit hold,
                         input logic [1023:0] edout, input logic [7:0] eraddr);
    logic [1023:0] mdout;
    logic [7:0]    mra;
    logic [4095:0] vpk;
    int            k;
    int            nwe;
    int            r;
    bit            fin;
    model_run(d, al, mdout, mra, vpk);
    alias_mode = al;
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(negedge clk);
    chk($sformatf("%s busy rise", nm), 1024'(busy), 1024'(1));
    k   = 1;
    nwe = 0;
    fin = 1'b0;
    while (!fin && k <= 200) begin
      if (!hold) start = 1'b0;
      if (bus.ram_we) begin
        chk($sformatf("%s we cycle %0d", nm, nwe), 1024'(k), 1024'(1 + 17 * nwe));
        chk($sformatf("%s we addr %0d", nm, nwe), 1024'(bus.ram_addr), 1024'(nwe));
        if (nwe < 4)
          chk($sformatf("%s wdata %0d", nm, nwe), bus.ram_wdata, vpk[nwe*1024 +: 1024]);
        nwe++;
      end
      if (k >= 69 && (k - 69) % 19 == 0 && (k - 69) / 19 < 4) begin
        r = (k - 69) / 19;
        chk($sformatf("%s read addr %0d", nm, r), 1024'(bus.ram_addr), 1024'(eraddr[r*2 +: 2]));
      end
      if (done) begin
        chk($sformatf("%s done cycle", nm), 1024'(k), 1024'(145));
        chk($sformatf("%s dout", nm), dout, edout);
        fin = 1'b1;
      end else begin
        k++;
        @(negedge clk);
      end
    end
    if (!fin) begin
      n_checks++;
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles, expected 145", nm, k);
    end
    chk($sformatf("%s write count", nm), 1024'(nwe), 1024'(4));
    @(negedge clk);
    chk($sformatf("%s idle after done", nm), 1024'(busy), 1024'(0));
    chk($sformatf("%s cycles", nm), 1024'(cycles), 1024'(ExpCycles));
    chk($sformatf("%s dout held", nm), dout, edout);
    if (hold) begin
      @(negedge clk);
      chk($sformatf("%s second accept", nm), 1024'(busy), 1024'(1));
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk($sformatf("%s reset after rerun", nm), 1024'(busy), 1024'(0));
    end
  endtask

  typedef struct {
    logic [1023:0] din;
    bit            al;
    bit            hold;
    logic [1023:0] dout;
    logic [7:0]    raddr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [4095:0] vdummy;
    n_checks   = 0;
    n_err      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    din        = '0;
    alias_mode = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // Hand-computed: din=0 gives X1 doubling, X0=X1-1; aliased reads all hit V[3]={4,3}.
    vecs[0] = '{din: '0, al: 1'b0, hold: 1'b0, dout: {512'd128, 512'd127}, raddr: 8'h00};
    vecs[1] = '{din: '0, al: 1'b1, hold: 1'b0, dout: {512'd131, 512'd124}, raddr: 8'hff};
    vecs[2].din  = {8{128'hdeadbeef_01234567_89abcdef_f00dcafe}};
    vecs[2].al   = 1'b0;
    vecs[2].hold = 1'b0;
    vecs[3].din  = {32{32'h5a5a1234}};
    vecs[3].al   = 1'b0;
    vecs[3].hold = 1'b1;
    for (int i = 2; i < 4; i++)
      model_run(vecs[i].din, vecs[i].al, vecs[i].dout, vecs[i].raddr, vdummy);

    repeat (3) @(negedge clk);
    chk("reset busy", 1024'(busy), 1024'(0));
    chk("reset done", 1024'(done), 1024'(0));
    chk("reset ram_we", 1024'(bus.ram_we), 1024'(0));
    chk("reset ram_addr", 1024'(bus.ram_addr), 1024'(0));
    chk("reset dout", dout, '0);
    chk("reset salsa_b", 1024'(bus.salsa_b), '0);
    chk("reset salsa_bx", 1024'(bus.salsa_bx), '0);
    chk("reset cycles", 1024'(cycles), '0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++)
      run_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].al, vecs[i].hold,
              vecs[i].dout, vecs[i].raddr);

    // Abort in the read phase, then a fresh run must still complete normally.
    alias_mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    din   = vecs[2].din;
    @(negedge clk);
    start = 1'b0;
    repeat (89) @(negedge clk);
    chk("mid-run busy", 1024'(busy), 1024'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 1024'(busy), 1024'(0));
    chk("abort done", 1024'(done), 1024'(0));
    chk("abort ram_we", 1024'(bus.ram_we), 1024'(0));
    chk("abort ram_addr", 1024'(bus.ram_addr), 1024'(0));
    chk("abort salsa_b", 1024'(bus.salsa_b), '0);
    chk("abort cycles", 1024'(cycles), '0);
    run_one("post-abort", vecs[2].din, 1'b0, 1'b0, vecs[2].dout, vecs[2].raddr);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
